// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad state type, key code constants and encoding helpers
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // Layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
   function automatic logic [3:0] encode_key(input logic [1:0] row_idx, input logic [1:0] col_idx);
      logic [3:0] code;
      if (col_idx == 2'd3) begin
         code = KEY_A + {2'b00, row_idx};
      end else if (row_idx != 2'd3) begin
         code = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
      end else begin
         case (col_idx)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'h0;
            default: code = KEY_HASH;
         endcase
      end
      return code;
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] bits_n);
      logic [1:0] idx;
      if (!bits_n[0])      idx = 2'd0;
      else if (!bits_n[1]) idx = 2'd1;
      else if (!bits_n[2]) idx = 2'd2;
      else                 idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - parameterised-width two-flop synchroniser with synchronous active-low reset
module sync2 #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad column scanner with debounce and key encoding
module keypad_scanner #(
   parameter int SCAN_DIV     = 50_000,
   parameter int DEBOUNCE_CNT = 500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);
   import keypad_pkg::*;

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CNT);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

   kp_state_t        state, state_nxt;
   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic [DEB_W-1:0] stab_cnt, stab_nxt;
   logic [3:0]       rs, row_cap, cap_nxt, col_nxt, col_rot, code_nxt;
   logic [1:0]       col_idx;
   logic             valid_nxt, held_nxt;

   sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row_n),
      .q     (rs)
   );

   assign col_rot = {col_n[2:0], col_n[3]};
   assign col_idx = low_index(col_n);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= SCAN;
         div_cnt   <= '0;
         stab_cnt  <= '0;
         col_n     <= 4'b1110;
         row_cap   <= 4'hF;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_nxt;
         stab_cnt  <= stab_nxt;
         col_n     <= col_nxt;
         row_cap   <= cap_nxt;
         key_code  <= code_nxt;
         key_valid <= valid_nxt;
         key_held  <= held_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      stab_nxt  = stab_cnt;
      col_nxt   = col_n;
      cap_nxt   = row_cap;
      code_nxt  = key_code;
      valid_nxt = 1'b0;
      held_nxt  = key_held;
      case (state)
         SCAN: begin
            if (div_cnt == DIV_LAST) begin
               div_nxt = '0;
               if (rs != 4'hF) begin
                  cap_nxt   = rs;
                  stab_nxt  = '0;
                  state_nxt = DEBOUNCE;
               end else begin
                  col_nxt = col_rot;
               end
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            // Any deviation from the captured pattern restarts the dwell in this column.
            if (rs != row_cap) begin
               div_nxt   = '0;
               stab_nxt  = '0;
               state_nxt = SCAN;
            end else if (stab_cnt == DEB_LAST) begin
               code_nxt  = encode_key(low_index(row_cap), col_idx);
               valid_nxt = 1'b1;
               held_nxt  = 1'b1;
               stab_nxt  = '0;
               state_nxt = PRESSED;
            end else begin
               stab_nxt = stab_cnt + 1'b1;
            end
         end
         PRESSED: begin
            held_nxt = 1'b1;
            if (rs == 4'hF) begin
               stab_nxt  = '0;
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (rs != 4'hF) begin
               stab_nxt  = '0;
               state_nxt = PRESSED;
            end else if (stab_cnt == DEB_LAST) begin
               held_nxt  = 1'b0;
               col_nxt   = col_rot;
               div_nxt   = '0;
               stab_nxt  = '0;
               state_nxt = SCAN;
            end else begin
               stab_nxt = stab_cnt + 1'b1;
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

endmodule
